swipt_tx_sequencer: RTL and testbench

Frame-level transmit sequencer for the SWIPT downlink duty-cycle modulator. It accepts 8-bit words from two requesters (host command path and telemetry path), arbitrates between them round-robin, and frames each word into start, data, parity and stop bits. For each frame it drives the modulator's `program`/`write`/`read`/`data` controls with exact bit timing, and aborts cleanly when the power link (`swiptAlive`) drops.

---
 rtl/swipt_pkg.sv | 25 ++
 rtl/swipt_tx_sequencer_if.sv | 16 +
 rtl/swipt_rr_arbiter.sv | 36 +++
 rtl/swipt_tx_sequencer.sv | 178 +++++++++++++++++
 tb/tb_swipt_tx_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT downlink transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package swipt_pkg;

    // Frame sequencer states, in transmit order.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GUARD
    } state_t;

    // Modulator program codes.
    localparam logic [1:0] PROG_IDLE  = 2'b00;
    localparam logic [1:0] PROG_WRITE = 2'b11;

    localparam int FRAME_DATA_BITS = 8;

    // Width of the per-bit down-counter; covers BIT_CYCLES up to 2^20-1.
    localparam int CNT_W = 20;

endpackage

// File: rtl/swipt_tx_sequencer_if.sv
// Word request bus from the two requesters (bit 0 = host, bit 1 = telemetry).
// Latency: n/a (wires only); req_ready is combinational in the sequencer.
// Backpressure: a word moves when req_valid[i] & req_ready[i]; valid may wait indefinitely.
// Ports: req_valid/req_data0/req_data1 driven by requesters, req_ready driven by sequencer.
interface swipt_tx_sequencer_if;
    import swipt_pkg::*;

    logic [1:0]                 req_valid;
    logic [FRAME_DATA_BITS-1:0] req_data0;
    logic [FRAME_DATA_BITS-1:0] req_data1;
    logic [1:0]                 req_ready;

    modport master (output req_valid, output req_data0, output req_data1, input req_ready);
    modport slave  (input req_valid, input req_data0, input req_data1, output req_ready);

endinterface

// File: rtl/swipt_rr_arbiter.sv
// Two-requester round-robin arbiter; a tie goes to the requester that did not win last.
// Latency: grant is combinational from req_i; last_grant updates on the accept_i cycle.
// Backpressure: grant only advances when accept_i is high, so a stalled grant is held.
// Ports: clk/nrst, req_i (valids), accept_i (grant consumed), gnt_o (one-hot), win_id_o.
module swipt_rr_arbiter (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       win_id_o
);
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        win_id_o = 1'b0;
        case (req_i)
            2'b10:   win_id_o = 1'b1;
            2'b11:   win_id_o = ~last_grant_q;
            default: win_id_o = 1'b0;
        endcase
        gnt_o        = (req_i == 2'b00) ? 2'b00 : (win_id_o ? 2'b10 : 2'b01);
        last_grant_d = accept_i ? win_id_o : last_grant_q;
    end

    // Reset value 1 hands the first tie to requester 0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/swipt_tx_sequencer.sv
// Frames arbitrated 8-bit words as start/data(LSB first)/even-parity/stop bits for the SWIPT modulator.
// Latency: first START bit on outputs one cycle after transfer; frame lasts 11*BIT_CYCLES, done one cycle later.
// Backpressure: req_ready only in IDLE with the power link up; a dropped link aborts the frame without retry.
// Ports: clk, nrst (sync, active-low), swipt_alive_i, req_if (slave), program_o/write_o/read_o/data_o
//        to the modulator, busy_o/gnt_id_o/done_o/abort_o status.
module swipt_tx_sequencer #(
    parameter int BIT_CYCLES = 16384,
    parameter int GUARD_BITS = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       swipt_alive_i,
    swipt_tx_sequencer_if.slave        req_if,
    output logic [1:0]                 program_o,
    output logic                       write_o,
    output logic                       read_o,
    output logic                       data_o,
    output logic                       busy_o,
    output logic                       gnt_id_o,
    output logic                       done_o,
    output logic                       abort_o
);
    import swipt_pkg::*;

    localparam int                IDX_W        = $clog2(FRAME_DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_RELOAD   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [3:0]        GUARD_RELOAD = 4'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(FRAME_DATA_BITS - 1);

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [FRAME_DATA_BITS-1:0] shreg_q;
    logic                       par_q;
    logic [IDX_W-1:0]           bit_idx_q;
    logic [3:0]                 guard_q;
    logic                       gnt_id_q;
    logic [1:0]                 prog_q;
    logic                       write_q;
    logic                       data_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       abort_q;

    logic [1:0]                 gnt;
    logic                       win_id;
    logic                       accept;
    logic                       bit_end;
    logic [FRAME_DATA_BITS-1:0] word_sel;

    swipt_rr_arbiter u_arb (
        .clk      (clk),
        .nrst     (nrst),
        .req_i    (req_if.req_valid),
        .accept_i (accept),
        .gnt_o    (gnt),
        .win_id_o (win_id)
    );

    assign req_if.req_ready = ((state_q == S_IDLE) && swipt_alive_i) ? gnt : 2'b00;
    assign accept           = |(req_if.req_valid & req_if.req_ready);
    assign word_sel         = win_id ? req_if.req_data1 : req_if.req_data0;
    assign bit_end          = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            guard_q   <= '0;
            gnt_id_q  <= 1'b0;
            prog_q    <= PROG_IDLE;
            write_q   <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (state_q != S_IDLE && !swipt_alive_i) begin
                // Link lost: drop the word, park the modulator, flag it once.
                state_q <= S_IDLE;
                cnt_q   <= '0;
                prog_q  <= PROG_IDLE;
                write_q <= 1'b0;
                data_q  <= 1'b0;
                busy_q  <= 1'b0;
                abort_q <= 1'b1;
            end else begin
                if (state_q != S_IDLE) begin
                    cnt_q <= bit_end ? CNT_RELOAD : cnt_q - 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_q   <= S_START;
                            shreg_q   <= word_sel;
                            par_q     <= 1'b0;
                            bit_idx_q <= '0;
                            gnt_id_q  <= win_id;
                            cnt_q     <= CNT_RELOAD;
                            prog_q    <= PROG_WRITE;
                            write_q   <= 1'b1;
                            data_q    <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (bit_end) begin
                            state_q <= S_DATA;
                            data_q  <= shreg_q[0];
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            // The bit just sent folds into parity; the next one moves to [0].
                            par_q   <= par_q ^ shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                            if (bit_idx_q == LAST_IDX) begin
                                state_q <= S_PARITY;
                                data_q  <= par_q ^ shreg_q[0];
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                                data_q    <= shreg_q[1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state_q <= S_STOP;
                            data_q  <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            done_q  <= 1'b1;
                            prog_q  <= PROG_IDLE;
                            write_q <= 1'b0;
                            data_q  <= 1'b0;
                            if (GUARD_BITS > 0) begin
                                state_q <= S_GUARD;
                                guard_q <= GUARD_RELOAD;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    S_GUARD: begin
                        if (bit_end) begin
                            if (guard_q == '0) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                cnt_q   <= '0;
                            end else begin
                                guard_q <= guard_q - 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign program_o = prog_q;
    assign write_o   = write_q;
    assign read_o    = 1'b0;
    assign data_o    = data_q;
    assign busy_o    = busy_q;
    assign gnt_id_o  = gnt_id_q;
    assign done_o    = done_q;
    assign abort_o   = abort_q;

endmodule

// File: tb/tb_swipt_tx_sequencer.sv
// Directed bench for swipt_tx_sequencer: DUT A at BIT_CYCLES=8, DUT B at BIT_CYCLES=2, both GUARD_BITS=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_swipt_tx_sequencer;

    logic clk = 1'b0;
    logic nrst;
    logic alive;
    always #5 clk = ~clk;

    swipt_tx_sequencer_if ifa ();
    swipt_tx_sequencer_if ifb ();

    logic [1:0] prog_a, prog_b;
    logic write_a, read_a, data_a, busy_a, gnt_a, done_a, abort_a;
    logic write_b, read_b, data_b, busy_b, gnt_b, done_b, abort_b;

    swipt_tx_sequencer #(.BIT_CYCLES(8), .GUARD_BITS(2)) dut_a (
        .clk(clk), .nrst(nrst), .swipt_alive_i(alive), .req_if(ifa.slave),
        .program_o(prog_a), .write_o(write_a), .read_o(read_a), .data_o(data_a),
        .busy_o(busy_a), .gnt_id_o(gnt_a), .done_o(done_a), .abort_o(abort_a)
    );

    swipt_tx_sequencer #(.BIT_CYCLES(2), .GUARD_BITS(2)) dut_b (
        .clk(clk), .nrst(nrst), .swipt_alive_i(alive), .req_if(ifb.slave),
        .program_o(prog_b), .write_o(write_b), .read_o(read_b), .data_o(data_b),
        .busy_o(busy_b), .gnt_id_o(gnt_b), .done_o(done_b), .abort_o(abort_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Frame line bits, index 0 first on the wire: start, d0..d7, parity, stop.
    localparam logic [10:0] F_A5 = 11'b00101001011;
    localparam logic [10:0] F_01 = 11'b01000000011;
    localparam logic [10:0] F_02 = 11'b01000000101;
    localparam logic [10:0] F_FF = 11'b00111111111;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {program, write, read, data, busy, done, abort} of DUT A
    function automatic logic [15:0] vec_a();
        return 16'({prog_a, write_a, read_a, data_a, busy_a, done_a, abort_a});
    endfunction

    task automatic wait_ready(input logic [1:0] exp, input string tag);
        int k = 0;
        while (ifa.req_ready == 2'b00 && k < 300) begin
            tick();
            k++;
        end
        check(tag, 16'(ifa.req_ready), 16'(exp));
    endtask

    // Called in the first START cycle (T+1); returns at T+90.
    task automatic run_frame(input logic [10:0] bits, input logic id, input string tag);
        check({tag, "_gnt"}, 16'(gnt_a), 16'(id));
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 8; c++) begin
                if (b != 0 || c != 0) tick();
                check({tag, "_bit"}, vec_a(), 16'({2'b11, 1'b1, 1'b0, bits[b], 1'b1, 1'b0, 1'b0}));
            end
        end
        tick();
        check({tag, "_done"}, vec_a(), 16'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
        tick();
        check({tag, "_done_pulse"}, 16'(done_a), 16'(0));
    endtask

    initial begin
        nrst = 1'b0;
        alive = 1'b1;
        ifa.req_valid = 2'b00; ifa.req_data0 = 8'h00; ifa.req_data1 = 8'h00;
        ifb.req_valid = 2'b00; ifb.req_data0 = 8'h00; ifb.req_data1 = 8'h00;
        tick();
        tick();
        check("reset_a_outputs", vec_a(), 16'(0));
        check("reset_a_gnt", 16'(gnt_a), 16'(0));
        check("reset_b_outputs", 16'({prog_b, write_b, read_b, data_b, busy_b, done_b, abort_b, gnt_b}), 16'(0));

        // Single requester, word 0xA5.
        nrst = 1'b1;
        ifa.req_valid = 2'b01; ifa.req_data0 = 8'hA5;
        #1;
        check("a5_ready", 16'(ifa.req_ready), 16'(2'b01));
        tick();
        ifa.req_valid = 2'b00;
        run_frame(F_A5, 1'b0, "a5");

        // Request raised during GUARD: held off until the first IDLE cycle (T+105).
        ifa.req_valid = 2'b01; ifa.req_data0 = 8'h3D;
        #1;
        check("guard_ready_t90", 16'(ifa.req_ready), 16'(0));
        for (int i = 91; i <= 104; i++) begin
            tick();
            check("guard_ready", 16'({ifa.req_ready, busy_a}), 16'({2'b00, 1'b1}));
        end
        tick();
        check("guard_release_ready", 16'({ifa.req_ready, busy_a}), 16'({2'b01, 1'b0}));
        tick();
        check("3d_start", vec_a(), 16'({2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
        ifa.req_valid = 2'b00;
        for (int i = 0; i < 71; i++) tick();
        check("3d_last_data", 16'(data_a), 16'(0));
        tick();
        check("3d_parity", vec_a(), 16'({2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
        tick();
        tick();

        // Reset mid-PARITY with both requesters waiting.
        nrst = 1'b0;
        ifa.req_valid = 2'b11; ifa.req_data0 = 8'h01; ifa.req_data1 = 8'h02;
        tick();
        check("rst_parity_outputs", vec_a(), 16'(0));
        check("rst_parity_gnt", 16'(gnt_a), 16'(0));
        tick();
        check("rst_hold_outputs", vec_a(), 16'(0));
        nrst = 1'b1;
        #1;
        check("rst_first_tie", 16'(ifa.req_ready), 16'(2'b01));

        // Round robin with both held.
        tick();
        run_frame(F_01, 1'b0, "rr1");
        wait_ready(2'b10, "rr2_ready");
        tick();
        run_frame(F_02, 1'b1, "rr2");
        wait_ready(2'b01, "rr3_ready");
        tick();
        run_frame(F_01, 1'b0, "rr3");
        wait_ready(2'b10, "rr4_ready");
        tick();
        run_frame(F_02, 1'b1, "rr4");

        // Link drop during the 4th data bit of a requester-0 frame.
        wait_ready(2'b01, "ab_ready");
        tick();
        check("ab_gnt", 16'(gnt_a), 16'(0));
        for (int i = 0; i < 34; i++) tick();
        check("ab_pre", vec_a(), 16'({2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        alive = 1'b0;
        tick();
        check("ab_outputs", vec_a(), 16'({2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
        check("ab_ready_low", 16'(ifa.req_ready), 16'(0));
        tick();
        check("ab_pulse", vec_a(), 16'(0));
        check("ab_still_low", 16'(ifa.req_ready), 16'(0));
        alive = 1'b1;
        #1;
        check("ab_next_winner", 16'(ifa.req_ready), 16'(2'b10));
        tick();
        check("ab_next_gnt", 16'({gnt_a, data_a, busy_a}), 16'(3'b111));
        ifa.req_valid = 2'b00;

        // BIT_CYCLES=2, word 0xFF, every cycle checked.
        ifb.req_valid = 2'b01; ifb.req_data0 = 8'hFF;
        #1;
        check("ff_ready", 16'(ifb.req_ready), 16'(2'b01));
        tick();
        ifb.req_valid = 2'b00;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 2; c++) begin
                if (b != 0 || c != 0) tick();
                check("ff_bit", 16'({prog_b, write_b, data_b, done_b}), 16'({2'b11, 1'b1, F_FF[b], 1'b0}));
            end
        end
        tick();
        check("ff_done", 16'({prog_b, write_b, data_b, done_b, busy_b}), 16'({2'b00, 1'b0, 1'b0, 1'b1, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
